// File: rtl/is_div_3_pkg.sv
// Shared types and helpers for the divisibility-by-3 datapath.
// Remainder codes, control FSM states and the serial mod-3 step.
package is_div_3_pkg;

    localparam logic [1:0] REM0 = 2'd0;
    localparam logic [1:0] REM1 = 2'd1;
    localparam logic [1:0] REM2 = 2'd2;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_ASSEMBLE = 1'b1
    } state_t;

    // Appending a bit doubles the value and adds the bit: r' = (2r + b) mod 3.
    function automatic logic [1:0] next_rem(input logic [1:0] r, input logic b);
        logic [1:0] result;
        result = REM0;
        case (r)
            REM0:    result = b ? REM1 : REM0;
            REM1:    result = b ? REM0 : REM2;
            REM2:    result = b ? REM2 : REM1;
            default: result = REM0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/mod3_step.sv
// Combinational single-bit step of the MSB-first mod-3 remainder machine.
module mod3_step
    import is_div_3_pkg::*;
(
    input  logic [1:0] r,
    input  logic       din,
    output logic [1:0] r_next
);

    assign r_next = next_rem(r, din);

endmodule

// File: rtl/is_div_3_deser.sv
// Serial MSB-first deserializer that tags each completed word with its
// mod-3 remainder and keeps a saturating count of divisible words.
module is_div_3_deser
    import is_div_3_pkg::*;
#(
    parameter int SIZE  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    output logic [SIZE-1:0]  word_out,
    output logic             word_valid,
    output logic             div_out,
    output logic [1:0]       rem_out,
    output logic             frame_abort,
    output logic             busy,
    output logic [CNT_W-1:0] div_count
);

    localparam int              CW       = $clog2(SIZE + 1);
    localparam logic [CW-1:0]   LAST_IDX = CW'(SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t          state;
    logic [SIZE-1:0] shift_reg;
    logic [SIZE-1:0] shift_next;
    logic [CW-1:0]   bit_cnt;
    logic [1:0]      rem;
    logic [1:0]      rem_next;

    mod3_step u_step (
        .r      (rem),
        .din    (bit_in),
        .r_next (rem_next)
    );

    assign shift_next = {shift_reg[SIZE-2:0], bit_in};
    assign busy       = (state == ST_ASSEMBLE);

    // A frame_start always restarts a frame, even on the would-be last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            rem         <= REM0;
            word_out    <= '0;
            word_valid  <= 1'b0;
            div_out     <= 1'b0;
            rem_out     <= REM0;
            frame_abort <= 1'b0;
            div_count   <= '0;
        end else begin
            word_valid  <= 1'b0;
            frame_abort <= 1'b0;
            if (bit_valid) begin
                if (frame_start) begin
                    frame_abort <= (state == ST_ASSEMBLE);
                    state       <= ST_ASSEMBLE;
                    shift_reg   <= {{(SIZE-1){1'b0}}, bit_in};
                    bit_cnt     <= CW'(1);
                    rem         <= bit_in ? REM1 : REM0;
                end else if (state == ST_ASSEMBLE) begin
                    if (bit_cnt == LAST_IDX) begin
                        word_out   <= shift_next;
                        rem_out    <= rem_next;
                        div_out    <= (rem_next == REM0);
                        word_valid <= 1'b1;
                        if ((rem_next == REM0) && (div_count != CNT_MAX)) begin
                            div_count <= div_count + CNT_W'(1);
                        end
                        state     <= ST_IDLE;
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                        rem       <= REM0;
                    end else begin
                        shift_reg <= shift_next;
                        bit_cnt   <= bit_cnt + CW'(1);
                        rem       <= rem_next;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_is_div_3_deser.sv
// Self-checking bench for is_div_3_deser: directed frames against an
// arithmetic frame model, plus a CNT_W=2 instance for counter saturation.
module tb_is_div_3_deser;

    localparam int SIZE = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        frame_start = 1'b0;

    logic [SIZE-1:0] word_out, word_out_s;
    logic            word_valid, word_valid_s;
    logic            div_out, div_out_s;
    logic [1:0]      rem_out, rem_out_s;
    logic            frame_abort, frame_abort_s;
    logic            busy, busy_s;
    logic [15:0]     div_count;
    logic [1:0]      div_count_s;

    is_div_3_deser #(.SIZE(SIZE), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .word_out(word_out), .word_valid(word_valid),
        .div_out(div_out), .rem_out(rem_out), .frame_abort(frame_abort),
        .busy(busy), .div_count(div_count)
    );

    is_div_3_deser #(.SIZE(SIZE), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .word_out(word_out_s), .word_valid(word_valid_s),
        .div_out(div_out_s), .rem_out(rem_out_s), .frame_abort(frame_abort_s),
        .busy(busy_s), .div_count(div_count_s)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame model: accumulate the accepted bits as an integer, take % 3 at the end.
    bit m_busy;
    int m_bits, m_word, m_word_out, m_rem, m_count;
    bit m_valid, m_div, m_abort;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_bits = 0; m_word = 0; m_word_out = 0; m_rem = 0;
            m_count = 0; m_valid = 0; m_div = 0; m_abort = 0;
        end else begin
            m_valid = 0;
            m_abort = 0;
            if (bit_valid) begin
                if (frame_start) begin
                    m_abort = m_busy;
                    m_busy  = 1;
                    m_word  = int'(bit_in);
                    m_bits  = 1;
                end else if (m_busy) begin
                    m_word = m_word * 2 + int'(bit_in);
                    m_bits++;
                    if (m_bits == SIZE) begin
                        m_word_out = m_word;
                        m_rem      = m_word % 3;
                        m_div      = (m_rem == 0);
                        m_valid    = 1;
                        if (m_div) m_count++;
                        m_busy = 0;
                    end
                end
            end
        end
    end

    // Event logs captured on each word_valid pulse for the directed checks.
    int log_cyc[$], log_word[$], log_rem[$], log_div[$], log_cnt[$];
    int abort_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("cyc_word_out", word_out, m_word_out);
            checkOutput("cyc_word_valid", word_valid, m_valid);
            checkOutput("cyc_div_out", div_out, m_div);
            checkOutput("cyc_rem_out", rem_out, m_rem);
            checkOutput("cyc_frame_abort", frame_abort, m_abort);
            checkOutput("cyc_busy", busy, m_busy);
            checkOutput("cyc_div_count", div_count, (m_count > 65535) ? 65535 : m_count);
            checkOutput("cyc_div_count_sat", div_count_s, (m_count > 3) ? 3 : m_count);
            if (word_valid) begin
                log_cyc.push_back(cyc);
                log_word.push_back(int'(word_out));
                log_rem.push_back(int'(rem_out));
                log_div.push_back(int'(div_out));
                log_cnt.push_back(int'(div_count));
            end
            if (frame_abort) abort_cnt++;
        end
    end

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic clearLogs();
        log_cyc.delete(); log_word.delete(); log_rem.delete();
        log_div.delete(); log_cnt.delete();
        abort_cnt = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bit_valid = 0;
            frame_start = 0;
            bit_in = 0;
        end
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst_n = 0;
        bit_valid = 0;
        frame_start = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        clearLogs();
    endtask

    // Sends the first nbits of w MSB-first, with `stalls` idle cycles scattered inside.
    task automatic applyStimulus(input logic [SIZE-1:0] w, input int nbits,
                                 input int stalls, output int first_cyc);
        int gaps[SIZE];
        first_cyc = 0;
        for (int i = 0; i < SIZE; i++) gaps[i] = 0;
        for (int s = 0; s < stalls; s++) gaps[$urandom_range(1, nbits - 1)]++;
        for (int i = 0; i < nbits; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                @(negedge clk);
                bit_valid = 0;
                frame_start = 0;
                checkOutput("stall_busy", busy, 1);
            end
            @(negedge clk);
            if (i == 0) first_cyc = cyc;
            bit_in      = w[SIZE-1-i];
            bit_valid   = 1;
            frame_start = (i == 0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int f, f2;
        int sat_exp[5];
        sat_exp = '{1, 2, 3, 3, 3};

        // Reset values
        resetDut();
        @(negedge clk);
        checkOutput("rst_word_out", word_out, 0);
        checkOutput("rst_word_valid", word_valid, 0);
        checkOutput("rst_div_out", div_out, 0);
        checkOutput("rst_rem_out", rem_out, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_div_count", div_count, 0);

        // Test 1: 0x09, no stalls
        $display("[TB] test 1: single frame 0x09");
        applyStimulus(8'h09, 8, 0, f);
        idle(2);
        checkOutput("t1_nvalid", log_cyc.size(), 1);
        checkOutput("t1_latency", qget(log_cyc, 0) - f, 8);
        checkOutput("t1_word", word_out, 8'h09);
        checkOutput("t1_div", div_out, 1);
        checkOutput("t1_rem", rem_out, 0);
        checkOutput("t1_count", div_count, 1);

        // Test 2: 0xFF then 0x07 back-to-back
        $display("[TB] test 2: back-to-back 0xFF, 0x07");
        resetDut();
        applyStimulus(8'hFF, 8, 0, f);
        applyStimulus(8'h07, 8, 0, f2);
        idle(2);
        checkOutput("t2_nvalid", log_cyc.size(), 2);
        checkOutput("t2_word0", qget(log_word, 0), 8'hFF);
        checkOutput("t2_div0", qget(log_div, 0), 1);
        checkOutput("t2_rem0", qget(log_rem, 0), 0);
        checkOutput("t2_cnt0", qget(log_cnt, 0), 1);
        checkOutput("t2_word1", qget(log_word, 1), 8'h07);
        checkOutput("t2_div1", qget(log_div, 1), 0);
        checkOutput("t2_rem1", qget(log_rem, 1), 1);
        checkOutput("t2_cnt1", qget(log_cnt, 1), 1);
        checkOutput("t2_period", qget(log_cyc, 1) - qget(log_cyc, 0), 8);

        // Test 3: 0x0E with three stall cycles
        $display("[TB] test 3: 0x0E with stalls");
        clearLogs();
        applyStimulus(8'h0E, 8, 3, f);
        idle(2);
        checkOutput("t3_nvalid", log_cyc.size(), 1);
        checkOutput("t3_latency", qget(log_cyc, 0) - f, 11);
        checkOutput("t3_word", word_out, 8'h0E);
        checkOutput("t3_rem", rem_out, 2);
        checkOutput("t3_div", div_out, 0);
        checkOutput("t3_count", div_count, 1);

        // Test 4: partial frame aborted by a new frame 0x03
        $display("[TB] test 4: abort then 0x03");
        clearLogs();
        applyStimulus(8'hA0, 3, 0, f);
        idle(1);
        checkOutput("t4_busy_partial", busy, 1);
        checkOutput("t4_word_hold", word_out, 8'h0E);
        applyStimulus(8'h03, 8, 0, f);
        idle(2);
        checkOutput("t4_aborts", abort_cnt, 1);
        checkOutput("t4_nvalid", log_cyc.size(), 1);
        checkOutput("t4_word", word_out, 8'h03);
        checkOutput("t4_div", div_out, 1);
        checkOutput("t4_count", div_count, 2);

        // Test 5: asynchronous reset in the middle of a frame
        $display("[TB] test 5: reset mid-frame");
        resetDut();
        applyStimulus(8'h09, 8, 0, f);
        applyStimulus(8'hB5, 5, 0, f);
        #2;
        rst_n = 0;
        bit_valid = 0;
        frame_start = 0;
        #1;
        checkOutput("t5_word_out", word_out, 0);
        checkOutput("t5_word_valid", word_valid, 0);
        checkOutput("t5_div_out", div_out, 0);
        checkOutput("t5_rem_out", rem_out, 0);
        checkOutput("t5_frame_abort", frame_abort, 0);
        checkOutput("t5_busy", busy, 0);
        checkOutput("t5_div_count", div_count, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        clearLogs();
        applyStimulus(8'h0C, 8, 0, f);
        idle(2);
        checkOutput("t5_word", word_out, 8'h0C);
        checkOutput("t5_div", div_out, 1);
        checkOutput("t5_count", div_count, 1);
        checkOutput("t5_aborts", abort_cnt, 0);

        // Test 6: saturation of the 2-bit counter
        $display("[TB] test 6: counter saturation");
        resetDut();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(8'h06, 8, 0, f);
            idle(1);
            checkOutput("t6_sat_count", div_count_s, sat_exp[k]);
            checkOutput("t6_wide_count", div_count, k + 1);
        end

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/is_div_3_deser.md
# is_div_3_deser

Serial front-end for the divisibility-by-3 datapath. It accepts a framed MSB-first bitstream, assembles SIZE-bit words, and presents each completed word with a one-cycle valid pulse to the downstream combinational `is_div_3_top` checker. In parallel it runs a bit-serial mod-3 remainder state machine, so every word carries its own divisibility flag and remainder. It also keeps a saturating count of divisible frames.

## Interface
Parameters:
- `SIZE`, 8, word width in bits; legal range is SIZE ≥ 2.
- `CNT_W`, 16, width of the divisible-frame counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `bit_in`  in  1  serial data, MSB of the word first.
- `bit_valid`  in  1  `bit_in` is valid this cycle.
- `frame_start`  in  1  marks the first bit of a frame; meaningful only when `bit_valid`=1.
- `word_out`  out  SIZE  last completed word; feeds `is_div_3_top.digit`.
- `word_valid`  out  1  one-cycle pulse; `word_out`, `div_out` and `rem_out` are new.
- `div_out`  out  1  1 when the completed word mod 3 == 0.
- `rem_out`  out  2  remainder of the completed word mod 3, in the range 0..2.
- `frame_abort`  out  1  one-cycle pulse; an unfinished frame was discarded.
- `busy`  out  1  a frame is being assembled.
- `div_count`  out  CNT_W  saturating count of words with `div_out`=1.

## Operation
- Control FSM states:
  - IDLE: waits for a frame start.
  - ASSEMBLE: collects the remaining bits of the frame.
- A bit is *accepted* when `bit_valid`=1 and one of these holds:
  - the FSM is in IDLE and `frame_start`=1, or
  - the FSM is in ASSEMBLE.
- IDLE -> ASSEMBLE on `bit_valid & frame_start`:
  - shift register <= `bit_in`;
  - bit counter <= 1;
  - remainder <= `bit_in`.
- IDLE with `bit_valid`=1 and `frame_start`=0: the bit is dropped and no output changes.
- ASSEMBLE, accepted bit with `frame_start`=0:
  - shift register <= {shift, `bit_in`};
  - counter increments;
  - remainder <= (2·r + `bit_in`) mod 3.
- Remainder transitions (r, bit -> r'):
  - (0,0)->0, (0,1)->1
  - (1,0)->2, (1,1)->0
  - (2,0)->1, (2,1)->2
- Frame completion: when the SIZE-th bit is accepted, on that clock edge:
  - `word_out` <= the full word;
  - `rem_out` <= the final remainder;
  - `div_out` <= (final remainder == 0);
  - `word_valid` <= 1;
  - the FSM returns to IDLE.
- `bit_valid`=0 in ASSEMBLE: a stall. All state holds, and there is no timeout.
- `frame_start`=1 with `bit_valid`=1 in ASSEMBLE, including on the would-be SIZE-th bit:
  - the partial frame is discarded and `frame_abort` pulses;
  - the current bit becomes bit 1 of a new frame;
  - the FSM stays in ASSEMBLE.
- `word_out`, `div_out` and `rem_out` hold their values until the next completion. An aborted frame never updates them.
- `div_count` increments on the same edge that sets `word_valid` with `div_out`=1. It saturates at 2^CNT_W−1 and never wraps.
- `busy` = (FSM state == ASSEMBLE).

## Timing
- Reset values: FSM in IDLE, and all outputs 0 (`word_out`=0, `word_valid`=0, `div_out`=0, `rem_out`=0, `frame_abort`=0, `busy`=0, `div_count`=0). Counter, shift register and remainder are also cleared.
- Reset asserted mid-frame: the partial frame is lost and no `frame_abort` is issued.
- Latency: `word_valid` is high in the cycle after the edge on which the last bit is accepted. With no stalls this is SIZE cycles after the first bit is presented.
- Back-to-back frames:
  - a `frame_start` in the cycle where `word_valid` is high is accepted;
  - the minimum frame period is SIZE cycles.
- `word_valid` and `frame_abort` are never high together: a completion edge and an abort edge are mutually exclusive.
- All outputs are registered. There is no combinational path from input to output.

## Structure
- Shared package `is_div_3_pkg`:
  - remainder encoding constants REM0/REM1/REM2 (2 bits);
  - FSM state constants ST_IDLE/ST_ASSEMBLE;
  - a next-remainder function.
- One sub-module, `mod3_step`: combinational, 2-bit r and 1-bit bit in, 2-bit r' out. It is reused by later serial stages.
- The bit counter width is $clog2(SIZE+1).
- The downstream `is_div_3_top` connects at the integration level and is not instantiated here.

## Test plan
1. SIZE=8, frame 0x09 with no stalls -> `word_valid` pulses 8 cycles after the first bit; `word_out`=0x09, `div_out`=1, `rem_out`=0, `div_count`=1.
2. Frames 0xFF then 0x07 back-to-back:
   - 0xFF -> `div_out`=1, `rem_out`=0;
   - 0x07 -> `div_out`=0, `rem_out`=1;
   - `div_count`=1 after the first frame and unchanged after the second;
   - the second `word_valid` comes exactly 8 cycles after the first.
3. Frame 0x0E (14) with `bit_valid` low for 3 random gaps -> result `rem_out`=2, `div_out`=0; `busy` held high throughout; `word_valid` delayed by exactly the stall count.
4. Abort: send 3 bits, then a `frame_start` with frame 0x03 -> `frame_abort` pulses once; `word_out`=0x03, `div_out`=1; the earlier word is unchanged until completion.
5. Reset mid-frame, after 5 bits:
   - all outputs read 0 immediately (asynchronously);
   - after release, frame 0x0C -> `div_out`=1, `div_count`=1.
6. CNT_W=2, five frames 0x06 -> `div_count` reads 1, 2, 3, 3, 3 (saturated, no wrap).
